// File: rtl/btn_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : btn_cmd_encoder
// Brief    : Debounces four active-low keys, latches the slide switches on
//            each accepted press, and drives the matching Processor command
//            code for HOLD_CYCLES cycles followed by GAP_CYCLES idle cycles.
// Option   : define BTN_ENC_SYNC_EN to add 2-flop synchronizers on key/sw.
// Revision : 1.0 - initial release
// ============================================================================
module btn_cmd_encoder #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int HOLD_CYCLES     = 4,
   parameter int GAP_CYCLES      = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] key,
   input  logic [7:0] sw,
   output logic [7:0] bytePos,
   output logic [2:0] btn,
   output logic       busy
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES);
   localparam int TMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [DW-1:0] c_DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] c_HOLD_LAST = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] c_GAP_LAST  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   logic [3:0] w_key;
   logic [7:0] w_sw;

`ifdef BTN_ENC_SYNC_EN
   logic [3:0] r_key_s1, r_key_s2;
   logic [7:0] r_sw_s1, r_sw_s2;

   // Two-flop synchronizers; keys reset to released, switches to zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_key_s1 <= 4'hF;
         r_key_s2 <= 4'hF;
         r_sw_s1  <= 8'h00;
         r_sw_s2  <= 8'h00;
      end else begin
         r_key_s1 <= key;
         r_key_s2 <= r_key_s1;
         r_sw_s1  <= sw;
         r_sw_s2  <= r_sw_s1;
      end
   end

   assign w_key = r_key_s2;
   assign w_sw  = r_sw_s2;
`else
   assign w_key = key;
   assign w_sw  = sw;
`endif

   logic [DW-1:0] r_dcnt [4];
   logic [3:0]    r_stable;
   logic [3:0]    r_stable_d;
   logic [3:0]    r_press;

   // Per-key debounce counters, stable state and registered 1->0 press pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) r_dcnt[i] <= '0;
         r_stable   <= 4'hF;
         r_stable_d <= 4'hF;
         r_press    <= 4'h0;
      end else begin
         r_stable_d <= r_stable;
         r_press    <= r_stable_d & ~r_stable;
         for (int i = 0; i < 4; i++) begin
            if (w_key[i] != r_stable[i]) begin
               if (r_dcnt[i] == c_DEB_LAST) begin
                  r_stable[i] <= w_key[i];
                  r_dcnt[i]   <= '0;
               end else begin
                  r_dcnt[i]   <= r_dcnt[i] + DW'(1);
               end
            end else begin
               r_dcnt[i] <= '0;
            end
         end
      end
   end

   state_t        r_state, w_state_nxt;
   logic [TW-1:0] r_tcnt, w_tcnt_nxt;
   logic [2:0]    r_btn, w_btn_nxt;
   logic [7:0]    r_byte, w_byte_nxt;
   logic          r_busy, w_busy_nxt;

   // FSM registers; every output comes straight from one of these flops
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_tcnt  <= '0;
         r_btn   <= 3'b000;
         r_byte  <= 8'h00;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_tcnt  <= w_tcnt_nxt;
         r_btn   <= w_btn_nxt;
         r_byte  <= w_byte_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   // Next-state logic: accept one press in IDLE (lowest key wins), hold, gap
   always_comb begin
      w_state_nxt = r_state;
      w_tcnt_nxt  = r_tcnt;
      w_btn_nxt   = r_btn;
      w_byte_nxt  = r_byte;
      w_busy_nxt  = r_busy;
      case (r_state)
         S_IDLE: begin
            w_btn_nxt  = 3'b000;
            w_busy_nxt = 1'b0;
            w_tcnt_nxt = '0;
            if (|r_press) begin
               w_state_nxt = S_ISSUE;
               w_busy_nxt  = 1'b1;
               w_byte_nxt  = w_sw;
               if (r_press[0])      w_btn_nxt = 3'b011;
               else if (r_press[1]) w_btn_nxt = 3'b110;
               else if (r_press[2]) w_btn_nxt = 3'b100;
               else                 w_btn_nxt = 3'b001;
            end
         end
         S_ISSUE: begin
            if (r_tcnt == c_HOLD_LAST) begin
               w_tcnt_nxt = '0;
               w_btn_nxt  = 3'b000;
               if (GAP_CYCLES == 0) begin
                  w_state_nxt = S_IDLE;
                  w_busy_nxt  = 1'b0;
               end else begin
                  w_state_nxt = S_GAP;
               end
            end else begin
               w_tcnt_nxt = r_tcnt + TW'(1);
            end
         end
         S_GAP: begin
            if (r_tcnt == c_GAP_LAST) begin
               w_tcnt_nxt  = '0;
               w_state_nxt = S_IDLE;
               w_busy_nxt  = 1'b0;
            end else begin
               w_tcnt_nxt = r_tcnt + TW'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_tcnt_nxt  = '0;
            w_btn_nxt   = 3'b000;
            w_busy_nxt  = 1'b0;
         end
      endcase
   end

   assign bytePos = r_byte;
   assign btn     = r_btn;
   assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_btn_cmd_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_btn_cmd_encoder
// Brief    : Scoreboard bench for btn_cmd_encoder (DEBOUNCE=4, HOLD=3, GAP=2).
//            Stimulus pushes expected commands; a monitor pops them whenever
//            btn becomes non-zero and also measures hold/busy lengths.
// Revision : 1.0 - initial release
// ============================================================================
module tb_btn_cmd_encoder;

   localparam int DEB  = 4;
   localparam int HOLD = 3;
   localparam int GAP  = 2;
`ifdef BTN_ENC_SYNC_EN
   localparam int S = 2;
`else
   localparam int S = 0;
`endif

   typedef struct {
      logic [2:0] code;
      logic [7:0] pos;
      int         at_edge;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] key = 4'hF;
   logic [7:0] sw  = 8'h00;
   logic [7:0] bytePos;
   logic [2:0] btn;
   logic       busy;

   int   cyc   = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];

   btn_cmd_encoder #(
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD),
      .GAP_CYCLES     (GAP)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .key    (key),
      .sw     (sw),
      .bytePos(bytePos),
      .btn    (btn),
      .busy   (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d (edge %0d)", name, act, req, cyc);
      end
   endtask

   // Called on a negedge: key goes low, first sampled on the next edge t
   task automatic press_key(input int idx, input logic [7:0] v, input logic [2:0] code);
      exp_t e;
      sw       = v;
      key[idx] = 1'b0;
      e.code    = code;
      e.pos     = v;
      e.at_edge = cyc + 1 + S + DEB + 1;
      q.push_back(e);
   endtask

   task automatic settle();
      repeat (S + DEB + HOLD + GAP + 4) @(negedge clk);
   endtask

   // Monitor: pop an expectation on each new command, time hold and busy
   logic [2:0] prev_btn  = 3'b000;
   logic       prev_busy = 1'b0;
   int         hold_cnt  = 0;
   int         busy_cnt  = 0;

   always @(negedge clk) begin
      if (!rst) begin
         prev_btn  = 3'b000;
         prev_busy = 1'b0;
         hold_cnt  = 0;
         busy_cnt  = 0;
      end else begin
         if (btn != 3'b000 && prev_btn == 3'b000) begin
            n_cmp++;
            if (q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_cmd: got btn=%b bytePos=%0d at edge %0d, required no command",
                        btn, bytePos, cyc);
            end else begin
               exp_t e;
               e = q.pop_front();
               if (btn !== e.code || bytePos !== e.pos || cyc != e.at_edge) begin
                  n_err++;
                  $display("FAIL cmd: got btn=%b bytePos=%0d edge=%0d, required btn=%b bytePos=%0d edge=%0d",
                           btn, bytePos, cyc, e.code, e.pos, e.at_edge);
               end
            end
         end
         if (btn != 3'b000) begin
            hold_cnt++;
         end else if (prev_btn != 3'b000) begin
            check("hold_len", hold_cnt, HOLD);
            hold_cnt = 0;
         end
         if (busy) begin
            busy_cnt++;
         end else if (prev_busy) begin
            check("busy_len", busy_cnt, HOLD + GAP);
            busy_cnt = 0;
         end
         prev_btn  = btn;
         prev_busy = busy;
      end
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_btn", int'(btn), 0);
      check("rst_bytePos", int'(bytePos), 0);
      check("rst_busy", int'(busy), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic command: sw=10 on key[0]
      press_key(0, 8'd10, 3'b011);
      settle();
      key = 4'hF;
      repeat (S + DEB + 3) @(negedge clk);
      check("bytePos_hold", int'(bytePos), 10);

      // Bounce on key[1] for 12 cycles, then a clean press
      for (int k = 0; k < 3; k++) begin
         key[1] = 1'b0;
         repeat (2) @(negedge clk);
         key[1] = 1'b1;
         repeat (2) @(negedge clk);
      end
      press_key(1, 8'h5A, 3'b110);
      settle();
      key = 4'hF;
      repeat (S + DEB + 3) @(negedge clk);

      // Simultaneous key[2] and key[3]: only key[2] is issued
      press_key(2, 8'd33, 3'b100);
      key[3] = 1'b0;
      settle();
      repeat (10) @(negedge clk);
      key = 4'hF;
      repeat (S + DEB + 3) @(negedge clk);

      // key[3] press lands during GAP of key[0] command and is dropped
      press_key(0, 8'd7, 3'b011);
      repeat (4) @(negedge clk);
      key[3] = 1'b0;
      settle();
      check("busy_after_drop", int'(busy), 0);
      key = 4'hF;
      repeat (S + DEB + 3) @(negedge clk);
      press_key(3, 8'd200, 3'b001);
      settle();
      key = 4'hF;
      repeat (S + DEB + 3) @(negedge clk);
      check("bytePos_last", int'(bytePos), 200);

      // Reset mid-ISSUE
      press_key(1, 8'd99, 3'b110);
      for (int k = 0; k < 50 && btn == 3'b000; k++) @(negedge clk);
      check("issue_seen", int'(btn != 3'b000), 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      key = 4'hF;
      #1;
      check("midrst_btn", int'(btn), 0);
      check("midrst_bytePos", int'(bytePos), 0);
      check("midrst_busy", int'(busy), 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("post_rst_idle", int'({btn, bytePos, busy}), 0);
      end

      check("queue_empty", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/btn_cmd_encoder.md
# btn_cmd_encoder

- Front-end that turns the board's raw push-buttons and slide switches into the Processor command interface (`bytePos[7:0]`, `btn[2:0]`).
- Debounces four active-low keys and latches the switch value on each accepted press.
- Drives the matching command code for a fixed number of cycles, then returns to idle.
- Sits between the board pins and `Processor`, in place of the stimulus the processor bench drives by hand.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive identical samples needed before a key's stable state changes (≥2).
- `HOLD_CYCLES`, default 4: cycles a command code is held on `btn` (≥1).
- `GAP_CYCLES`, default 2: forced idle cycles after each command (≥0).
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `key` input 4: raw push-buttons, active-low (0 = pressed), asynchronous to `clk`.
- `sw` input 8: raw slide switches; sampled only on an accepted press.
- `bytePos` output 8: operand to Processor; registered.
- `btn` output 3: command code to Processor; registered; 3'b000 = no command.
- `busy` output 1: high while in ISSUE or GAP.

## Operation
- Command map, fixed:
  - key[0] → 3'b011 (write position)
  - key[1] → 3'b110 (select algorithm 1)
  - key[2] → 3'b100 (write data)
  - key[3] → 3'b001 (step)
- Debounce, per key:
  - Stable state resets to 1 (released); counter resets to 0.
  - If the sample differs from stable state, the counter increments; when it reaches DEBOUNCE_CYCLES−1 on a differing sample, stable state flips and the counter clears.
  - An equal sample clears the counter. Glitches shorter than DEBOUNCE_CYCLES samples never change state.
- Press event: stable state goes 1→0. A one-cycle internal `press[i]` is registered. Releases (0→1) produce no event.
- FSM states:
  - IDLE: `btn`=0. Any `press` moves to ISSUE. The lowest-index key wins; other same-cycle presses are dropped. The `sw` value is latched into `bytePos`.
  - ISSUE: `btn`=code for exactly HOLD_CYCLES cycles. Then go to GAP, or to IDLE if GAP_CYCLES=0.
  - GAP: `btn`=0 for exactly GAP_CYCLES cycles, then IDLE.
- Presses arriving in ISSUE or GAP are dropped, not queued. The key must be released and pressed again.
- `bytePos` holds its last latched value after ISSUE, until the next accepted press.
- Reset (asynchronous, any state): FSM → IDLE; `btn`=0, `bytePos`=0, `busy`=0; all counters 0; stable states = released.
  - A key held low through reset release is accepted once, after DEBOUNCE_CYCLES samples.

## Timing
- Let S = synchronizer depth: 2 if `BTN_ENC_SYNC_EN` is defined, else 0.
- Key low from edge t, held steady:
  - Stable flips at edge t+S+DEBOUNCE_CYCLES−1.
  - `press` is registered at edge t+S+DEBOUNCE_CYCLES.
  - `btn`, `bytePos` and `busy` update at edge t+S+DEBOUNCE_CYCLES+1.
- `btn` is non-zero for HOLD_CYCLES consecutive cycles.
- `busy` is high for HOLD_CYCLES+GAP_CYCLES cycles and drops the same edge the FSM re-enters IDLE.
- Earliest next accepted command: the cycle after `busy` falls.
- `sw` is captured on the same edge `btn` goes non-zero. `sw` changes at any other time have no effect.
- All outputs come straight from flops; no combinational path from inputs to outputs.

## Configuration
- Macro `BTN_ENC_SYNC_EN`:
  - Defined: each of the 4 `key` bits and 8 `sw` bits passes through a 2-flop synchronizer (reset value 1 for `key`, 0 for `sw`) before debounce and latching. S=2.
  - Undefined: raw pins feed debounce and latching directly. S=0. For use with already-synchronous stimulus only.

## Test plan
Use DEBOUNCE_CYCLES=4, HOLD_CYCLES=3, GAP_CYCLES=2, macro undefined.
- Reset: `rst`=0 mid-ISSUE → `btn`=0, `bytePos`=0, `busy`=0 within the same cycle. After release with all keys high, outputs stay 0 for 20 cycles.
- Basic command: `sw`=8'd10, key[0] low from edge t → at edge t+5, `bytePos`=10 and `btn`=3'b011 for 3 cycles, then 0. `busy` is high for 5 cycles.
- Bounce: key[1] toggles every 2 cycles for 12 cycles, then stays low → no command during the bounce. Exactly one 3'b110 follows, 5 edges after the final low.
- Simultaneous: key[2] and key[3] debounced on the same edge → only 3'b100 is issued. No 3'b001 follows without a re-press.
- Busy drop: key[0] press accepted, then key[3] press accepted during GAP → no second command. Re-pressing key[3] after `busy` falls gives 3'b001.
- Macro defined: repeat the basic command → `btn` asserts at edge t+7. Switch-value latching is unchanged.
